// File: rtl/hazard_ctrl.sv
// Hazard and sequencing control for the 5-stage MIPS pipeline.
// Tracks the destinations of EX/MEM/WB instructions, interlocks load-use cases, flushes on taken branches, and drains on HALT.
module hazard_ctrl #(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [5:0]       id_opcode,
  input  logic [1:0]       id_type,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic [4:0]       id_rd,
  input  logic             ex_branch_taken,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             stall,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             halted,
  output logic [CNT_W-1:0] stall_count,
  output logic [1:0]       fsm_state,
  output logic [5:0]       wb_slot
);

  localparam logic [1:0] S_RUN    = 2'd0;
  localparam logic [1:0] S_DRAIN  = 2'd1;
  localparam logic [1:0] S_HALTED = 2'd2;

  localparam logic [1:0] T_R    = 2'd0;
  localparam logic [1:0] T_HALT = 2'd2;
  localparam logic [1:0] T_I    = 2'd3;

  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);

  logic [1:0]    state;
  logic [DW-1:0] drain_cnt;

  logic [4:0] ex_dst, mem_dst, wb_dst;
  logic       ex_wr, mem_wr, wb_wr, ex_load;

  logic [4:0] id_dst;
  logic       id_wr, id_load, use_rs, use_rt;
  logic       run, flush, load_use, issue;
  logic       rs_ex, rt_ex, rs_mem, rt_mem;

  // Decode what the ID instruction writes and which sources it actually reads.
  always_comb begin
    id_dst  = 5'd0;
    id_wr   = 1'b0;
    id_load = 1'b0;
    use_rs  = 1'b0;
    use_rt  = 1'b0;
    case (id_type)
      T_R: begin
        id_dst = id_rd;
        id_wr  = 1'b1;
        use_rs = 1'b1;
        use_rt = 1'b1;
      end
      T_I: begin
        use_rs = 1'b1;
        case (id_opcode)
          OP_ADDI, OP_ANDI: begin
            id_dst = id_rt;
            id_wr  = 1'b1;
          end
          OP_LW: begin
            id_dst  = id_rt;
            id_wr   = 1'b1;
            id_load = 1'b1;
          end
          OP_SW, OP_BEQ, OP_BNE: use_rt = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
    // Register 0 is hardwired, so a write to it is never a hazard.
    if (id_dst == 5'd0) begin
      id_wr   = 1'b0;
      id_load = 1'b0;
    end
  end

  assign rs_ex  = use_rs && (id_rs != 5'd0) && ex_wr  && (id_rs == ex_dst);
  assign rt_ex  = use_rt && (id_rt != 5'd0) && ex_wr  && (id_rt == ex_dst);
  assign rs_mem = use_rs && (id_rs != 5'd0) && mem_wr && (id_rs == mem_dst);
  assign rt_mem = use_rt && (id_rt != 5'd0) && mem_wr && (id_rt == mem_dst);

  assign run      = (state == S_RUN);
  assign flush    = run && ex_branch_taken;
  assign load_use = run && id_valid && ex_load && (rs_ex || rt_ex);
  assign stall    = load_use && !flush;
  assign issue    = run && id_valid && !flush && !stall;

  assign pc_write    = run && !stall;
  assign ifid_write  = run && !stall;
  assign ifid_flush  = flush;
  assign idex_bubble = !run || stall || flush;
  assign halted      = (state == S_HALTED);
  assign fsm_state   = state;
  assign wb_slot     = {wb_wr, wb_dst};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_dst  <= 5'd0;
      ex_wr   <= 1'b0;
      ex_load <= 1'b0;
      mem_dst <= 5'd0;
      mem_wr  <= 1'b0;
      wb_dst  <= 5'd0;
      wb_wr   <= 1'b0;
    end else begin
      ex_dst  <= issue ? id_dst : 5'd0;
      ex_wr   <= issue && id_wr;
      ex_load <= issue && id_load;
      mem_dst <= ex_dst;
      mem_wr  <= ex_wr;
      wb_dst  <= mem_dst;
      wb_wr   <= mem_wr;
    end
  end

  // Selects are captured as the instruction enters EX; the current EX occupant will then be in MEM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_a <= 2'b00;
      fwd_b <= 2'b00;
    end else if (!issue) begin
      fwd_a <= 2'b00;
      fwd_b <= 2'b00;
    end else begin
      fwd_a <= rs_ex ? 2'b10 : (rs_mem ? 2'b01 : 2'b00);
      fwd_b <= rt_ex ? 2'b10 : (rt_mem ? 2'b01 : 2'b00);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= '0;
    end else if (stall && (stall_count != {CNT_W{1'b1}})) begin
      stall_count <= stall_count + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_RUN;
      drain_cnt <= '0;
    end else begin
      case (state)
        S_RUN: begin
          if (issue && (id_type == T_HALT)) begin
            state     <= S_DRAIN;
            drain_cnt <= '0;
          end
        end
        S_DRAIN: begin
          if (drain_cnt == DRAIN_LAST) begin
            state <= S_HALTED;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        S_HALTED: state <= S_HALTED;
        default:  state <= S_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed hazard scenarios plus random instruction streams
// compared cycle by cycle against an in-flight instruction queue model.
module tb_hazard_ctrl;

  localparam int CNT_W        = 8;
  localparam int DRAIN_CYCLES = 3;
  localparam int CNT_MAX      = (1 << CNT_W) - 1;

  localparam logic [5:0] ADDI = 6'b001000;
  localparam logic [5:0] ANDI = 6'b001100;
  localparam logic [5:0] LW   = 6'b100011;
  localparam logic [5:0] SW   = 6'b101011;
  localparam logic [5:0] BEQ  = 6'b000100;
  localparam logic [5:0] BNE  = 6'b000101;

  typedef struct packed {
    logic       valid;
    logic [5:0] op;
    logic [1:0] ty;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
  } instr_t;

  typedef struct packed {
    logic [4:0] dst;
    logic       ld;
  } rec_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  instr_t cur = '0;
  logic   br = 1'b0;

  logic             pc_write, ifid_write, ifid_flush, idex_bubble, stall, halted;
  logic [1:0]       fwd_a, fwd_b, fsm_state;
  logic [CNT_W-1:0] stall_count;
  logic [5:0]       wb_slot;

  hazard_ctrl #(.DRAIN_CYCLES(DRAIN_CYCLES), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(cur.valid), .id_opcode(cur.op), .id_type(cur.ty),
    .id_rs(cur.rs), .id_rt(cur.rt), .id_rd(cur.rd),
    .ex_branch_taken(br),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .stall(stall),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .halted(halted),
    .stall_count(stall_count), .fsm_state(fsm_state), .wb_slot(wb_slot)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model: instructions in flight (index 0 = EX, 1 = MEM, 2 = WB)
  rec_t pipe_q[$];
  int   halt_age;
  int   exp_fa, exp_fb, exp_cnt;
  bit   m_run, m_flush, m_stall, m_issue;

  function automatic logic [4:0] dest_of(instr_t i);
    if (!i.valid) return 5'd0;
    if (i.ty == 2'd0) return i.rd;
    if (i.ty == 2'd3 && (i.op == ADDI || i.op == ANDI || i.op == LW)) return i.rt;
    return 5'd0;
  endfunction

  function automatic bit uses_rs(instr_t i);
    return i.valid && (i.ty == 2'd0 || i.ty == 2'd3) && i.rs != 5'd0;
  endfunction

  function automatic bit uses_rt(instr_t i);
    if (!i.valid || i.rt == 5'd0) return 1'b0;
    if (i.ty == 2'd0) return 1'b1;
    return i.ty == 2'd3 && (i.op == SW || i.op == BEQ || i.op == BNE);
  endfunction

  function automatic int fwd_for(logic [4:0] r);
    if (pipe_q[0].dst == r) return 2;
    if (pipe_q[1].dst == r) return 1;
    return 0;
  endfunction

  task automatic model_reset();
    pipe_q = {};
    for (int k = 0; k < 3; k++) pipe_q.push_back('0);
    halt_age = 0;
    exp_fa   = 0;
    exp_fb   = 0;
    exp_cnt  = 0;
  endtask

  task automatic compute();
    bit hit;
    m_run   = (halt_age == 0);
    m_flush = m_run && br;
    hit = pipe_q[0].ld && pipe_q[0].dst != 5'd0 &&
          ((uses_rs(cur) && cur.rs == pipe_q[0].dst) || (uses_rt(cur) && cur.rt == pipe_q[0].dst));
    m_stall = m_run && hit && !m_flush;
    m_issue = m_run && cur.valid && !m_flush && !m_stall;
  endtask

  task automatic check_all();
    int st;
    compute();
    st = (halt_age == 0) ? 0 : (halt_age <= DRAIN_CYCLES ? 1 : 2);
    check("pc_write", pc_write, m_run && !m_stall);
    check("ifid_write", ifid_write, m_run && !m_stall);
    check("ifid_flush", ifid_flush, m_flush);
    check("idex_bubble", idex_bubble, !m_run || m_stall || m_flush);
    check("stall", stall, m_stall);
    check("fwd_a", fwd_a, exp_fa);
    check("fwd_b", fwd_b, exp_fb);
    check("stall_count", stall_count, exp_cnt);
    check("halted", halted, st == 2);
    check("fsm_state", fsm_state, st);
    check("wb_slot", wb_slot, {pipe_q[2].dst != 5'd0, pipe_q[2].dst});
  endtask

  task automatic settle();
    #1;
    check_all();
  endtask

  task automatic advance();
    rec_t nr;
    @(posedge clk);
    exp_fa = (m_issue && uses_rs(cur)) ? fwd_for(cur.rs) : 0;
    exp_fb = (m_issue && uses_rt(cur)) ? fwd_for(cur.rt) : 0;
    nr.dst = m_issue ? dest_of(cur) : 5'd0;
    nr.ld  = m_issue && cur.ty == 2'd3 && cur.op == LW && nr.dst != 5'd0;
    pipe_q.push_front(nr);
    void'(pipe_q.pop_back());
    if (m_stall && exp_cnt < CNT_MAX) exp_cnt++;
    if (halt_age > 0 && halt_age < 1000) halt_age++;
    if (m_issue && cur.ty == 2'd2) halt_age = 1;
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    cur   = '0;
    br    = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // driver tasks
  function automatic instr_t mk(logic [1:0] ty, logic [5:0] op, int rs, int rt, int rd);
    instr_t i;
    i.valid = 1'b1; i.ty = ty; i.op = op;
    i.rs = 5'(rs); i.rt = 5'(rt); i.rd = 5'(rd);
    return i;
  endfunction

  task automatic drive(instr_t i, logic b);
    cur = i;
    br  = b;
  endtask

  task automatic step(instr_t i, logic b);
    drive(i, b);
    settle();
    advance();
  endtask

  function automatic instr_t rand_instr();
    instr_t i;
    logic [5:0] ops [7];
    ops = '{ADDI, ANDI, LW, SW, BEQ, BNE, 6'h0f};
    i.valid = ($urandom_range(0, 99) < 85);
    case ($urandom_range(0, 19))
      0, 1, 2, 3, 4, 5, 6: i.ty = 2'd0;
      7, 8, 9:             i.ty = 2'd1;
      default:             i.ty = 2'd3;
    endcase
    i.op = (i.ty == 2'd3) ? ops[$urandom_range(0, 6)] : 6'($urandom_range(0, 63));
    i.rs = 5'($urandom_range(0, 4));
    i.rt = 5'($urandom_range(0, 4));
    i.rd = 5'($urandom_range(0, 4));
    return i;
  endfunction

  task automatic random_run(int n);
    for (int k = 0; k < n; k++) step(rand_instr(), $urandom_range(0, 99) < 12);
  endtask

  instr_t nop_i;
  int     cnt_before;

  initial begin
    nop_i = '0;
    apply_reset();

    // load-use: one stall cycle, then the consumer takes the MEM->WB path
    step(mk(2'd3, LW, 1, 2, 0), 1'b0);
    drive(mk(2'd0, 6'd0, 2, 4, 3), 1'b0);
    settle();
    check("lu_stall", stall, 1'b1);
    check("lu_pc_write", pc_write, 1'b0);
    check("lu_bubble", idex_bubble, 1'b1);
    advance();
    settle();
    check("lu_released", stall, 1'b0);
    advance();
    drive(nop_i, 1'b0);
    settle();
    check("lu_fwd_a", fwd_a, 2'b01);
    check("lu_count", stall_count, 1);
    advance();

    // back-to-back ALU dependency, then with one NOP in between
    step(mk(2'd0, 6'd0, 1, 1, 5), 1'b0);
    step(mk(2'd0, 6'd0, 5, 5, 6), 1'b0);
    drive(nop_i, 1'b0);
    settle();
    check("ex_fwd_a", fwd_a, 2'b10);
    check("ex_fwd_b", fwd_b, 2'b10);
    advance();
    step(mk(2'd0, 6'd0, 1, 1, 5), 1'b0);
    step(nop_i, 1'b0);
    step(mk(2'd0, 6'd0, 5, 5, 6), 1'b0);
    drive(nop_i, 1'b0);
    settle();
    check("mem_fwd_a", fwd_a, 2'b01);
    check("mem_fwd_b", fwd_b, 2'b01);
    advance();

    // writes to $0 are never hazards
    step(mk(2'd3, ADDI, 1, 0, 0), 1'b0);
    drive(mk(2'd0, 6'd0, 0, 0, 7), 1'b0);
    settle();
    check("r0_stall", stall, 1'b0);
    advance();
    drive(nop_i, 1'b0);
    settle();
    check("r0_fwd_a", fwd_a, 2'b00);
    check("r0_fwd_b", fwd_b, 2'b00);
    advance();

    // branch flush overrides a load-use stall
    step(mk(2'd3, LW, 1, 2, 0), 1'b0);
    cnt_before = exp_cnt;
    drive(mk(2'd0, 6'd0, 2, 2, 3), 1'b1);
    settle();
    check("fl_flush", ifid_flush, 1'b1);
    check("fl_bubble", idex_bubble, 1'b1);
    check("fl_stall", stall, 1'b0);
    check("fl_pc_write", pc_write, 1'b1);
    advance();
    drive(nop_i, 1'b0);
    settle();
    check("fl_count", stall_count, cnt_before);
    advance();

    random_run(2000);

    // saturation: self-dependent loads stall every other cycle
    for (int k = 0; k < 2 * (CNT_MAX + 1) + 8; k++) step(mk(2'd3, LW, 2, 2, 0), 1'b0);
    drive(nop_i, 1'b0);
    settle();
    check("sat_count", stall_count, CNT_MAX);
    advance();

    // HALT drains for DRAIN_CYCLES, then holds; branches ignored meanwhile
    drive(mk(2'd2, 6'd0, 0, 0, 0), 1'b0);
    settle();
    check("halt_issue_pc", pc_write, 1'b1);
    advance();
    for (int k = 0; k < DRAIN_CYCLES; k++) begin
      drive(rand_instr(), $urandom_range(0, 1));
      settle();
      check("drain_pc_write", pc_write, 1'b0);
      check("drain_bubble", idex_bubble, 1'b1);
      check("drain_halted", halted, 1'b0);
      advance();
    end
    for (int k = 0; k < 4; k++) begin
      drive(rand_instr(), $urandom_range(0, 1));
      settle();
      check("hold_halted", halted, 1'b1);
      check("hold_pc_write", pc_write, 1'b0);
      advance();
    end

    // reset during the second drain cycle returns to RUN
    apply_reset();
    random_run(200);
    step(mk(2'd2, 6'd0, 0, 0, 0), 1'b0);
    step(nop_i, 1'b0);
    drive(nop_i, 1'b0);
    settle();
    apply_reset();
    check("rst_halted", halted, 1'b0);
    check("rst_pc_write", pc_write, 1'b1);
    check("rst_fsm", fsm_state, 2'd0);
    random_run(200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
